// File: rtl/cdc_2phase_src_tx.sv
// Source side of a 2-phase req/ack clock-domain crossing.
// Holds the payload in flops while one toggle-encoded request is in flight.
module cdc_2phase_src_tx #(
  parameter type T              = logic,
  parameter int  SYNC_STAGES    = 2,
  parameter int  TIMEOUT_CYCLES = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  T     src_data_i,
  input  logic src_valid_i,
  output logic src_ready_o,
  output logic async_req_o,
  output T     async_data_o,
  input  logic async_ack_i,
  output logic busy_o,
  output logic timeout_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cdc_2phase_src_tx: SYNC_STAGES must be at least 2");
  end

  logic [0:0]             r_state;
  logic                   r_req;
  T                       r_data;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_ack_sync;
  logic                   w_accept;

  assign w_ack_sync   = r_sync[SYNC_STAGES-1];
  assign src_ready_o  = (r_state == ST_IDLE) && !clr_i;
  assign w_accept     = src_valid_i && src_ready_o;
  assign async_req_o  = r_req;
  assign async_data_o = r_data;
  assign busy_o       = (r_state == ST_WAIT);

  // Ack synchronizer: the only consumer of the asynchronous ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], async_ack_i};
  end

  // Handshake FSM: launch on accept, return to idle once ack phase matches req.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data  <= src_data_i;
            r_req   <= ~r_req;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_ack_sync == r_req) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  if (TIMEOUT_CYCLES > 0) begin : g_wd
    localparam int            CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_cnt;
    logic          r_to;

    // Watchdog: saturating count of cycles spent waiting; sticky flag at limit.
    always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
        r_cnt <= '0;
        r_to  <= 1'b0;
      end else if (w_accept) begin
        r_cnt <= '0;
      end else if (r_state == ST_WAIT && r_cnt != LIM) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == LIM - 1'b1) r_to <= 1'b1;
      end
    end

    assign timeout_o = r_to;
  end else begin : g_no_wd
    assign timeout_o = 1'b0;
  end

endmodule

// File: tb/tb_cdc_2phase_src_tx.sv
// Directed bench for the 2-phase CDC source.
// Drives the ack by hand and checks outputs 1ns after each rising edge.
module tb_cdc_2phase_src_tx;

  typedef logic [7:0] byte_t;

  logic  clk = 1'b0;
  logic  rst, clr, valid, ack;
  byte_t din;

  logic  ready, req, busy, tmo;
  byte_t dout;
  logic  ready0, req0, busy0, tmo0;
  byte_t dout0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cdc_2phase_src_tx #(
    .T(byte_t), .SYNC_STAGES(2), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clr_i(clr),
    .src_data_i(din), .src_valid_i(valid), .src_ready_o(ready),
    .async_req_o(req), .async_data_o(dout), .async_ack_i(ack),
    .busy_o(busy), .timeout_o(tmo)
  );

  cdc_2phase_src_tx #(
    .T(byte_t), .SYNC_STAGES(2), .TIMEOUT_CYCLES(0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr),
    .src_data_i(din), .src_valid_i(valid), .src_ready_o(ready0),
    .async_req_o(req0), .async_data_o(dout0), .async_ack_i(ack),
    .busy_o(busy0), .timeout_o(tmo0)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; valid = 1'b0; ack = 1'b0; din = 8'h00;
    tick(2);
    rst = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_req", req, 0);
    chk("rst_data", dout, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", tmo, 0);

    // single transfer of 0xA5, ack echoed right after req toggles
    din = 8'hA5; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("a5_req", req, 1);
    chk("a5_data", dout, 8'hA5);
    chk("a5_busy", busy, 1);
    chk("a5_ready", ready, 0);
    ack = 1'b1;
    tick();
    chk("a5_busy_e", busy, 1);
    tick();
    chk("a5_busy_e1", busy, 1);
    chk("a5_ready_e1", ready, 0);
    tick();
    chk("a5_ready_e2", ready, 1);
    chk("a5_busy_e2", busy, 0);
    chk("a5_data_hold", dout, 8'hA5);
    chk("a5_tmo", tmo, 0);

    // back-to-back: 0x01 then 0x02 with valid held
    din = 8'h01; valid = 1'b1;
    tick();
    chk("b2b_req1", req, 0);
    chk("b2b_data1", dout, 8'h01);
    din = 8'h02; ack = 1'b0;
    tick();
    chk("b2b_noacc_req", req, 0);
    chk("b2b_noacc_data", dout, 8'h01);
    tick();
    chk("b2b_wait_busy", busy, 1);
    chk("b2b_wait_data", dout, 8'h01);
    tick();
    chk("b2b_idle_ready", ready, 1);
    chk("b2b_idle_req", req, 0);
    chk("b2b_idle_data", dout, 8'h01);
    tick();
    valid = 1'b0;
    chk("b2b_req2", req, 1);
    chk("b2b_data2", dout, 8'h02);
    ack = 1'b1;
    tick(3);
    chk("b2b_done_busy", busy, 0);
    chk("b2b_done_tmo", tmo, 0);

    // watchdog: no ack for a long time
    din = 8'h3C; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("wd_req", req, 0);
    tick(3);
    chk("wd_tmo_early", tmo, 0);
    tick();
    chk("wd_tmo_set", tmo, 1);
    chk("wd_busy", busy, 1);
    chk("wd_tmo_off", tmo0, 0);
    tick(2);
    chk("wd_tmo_sat", tmo, 1);
    ack = 1'b0;
    tick(3);
    chk("wd_late_busy", busy, 0);
    chk("wd_late_tmo", tmo, 1);
    clr = 1'b1;
    tick();
    chk("wd_clr_tmo", tmo, 0);
    chk("wd_clr_ready", ready, 0);
    clr = 1'b0;
    #1;
    chk("wd_unclr_ready", ready, 1);

    // clear during an in-flight transfer
    din = 8'h77; valid = 1'b1;
    tick();
    valid = 1'b0; clr = 1'b1;
    chk("clr_req", req, 1);
    tick(3);
    chk("clr_busy", busy, 1);
    chk("clr_ready", ready, 0);
    chk("clr_req_hold", req, 1);
    ack = 1'b1;
    tick(3);
    chk("clr_done_busy", busy, 0);
    chk("clr_done_ready", ready, 0);
    din = 8'h99; valid = 1'b1;
    tick();
    chk("clr_noacc_req", req, 1);
    chk("clr_noacc_data", dout, 8'h77);
    clr = 1'b0;
    #1;
    chk("clr_drop_ready", ready, 1);
    tick();
    valid = 1'b0;
    chk("clr_next_req", req, 0);
    chk("clr_next_data", dout, 8'h99);
    ack = 1'b0;
    tick(3);
    chk("clr_next_busy", busy, 0);

    // spurious ack toggle while idle
    ack = 1'b1;
    tick(4);
    chk("sp_ready", ready, 1);
    chk("sp_busy", busy, 0);
    chk("sp_req", req, 0);
    chk("sp_data", dout, 8'h99);
    ack = 1'b0;
    tick(3);

    // reset in the middle of a transfer
    din = 8'h11; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("mid_req", req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_req", req, 0);
    chk("mid_rst_data", dout, 8'h00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_2phase_src_tx.md
CDC_2PHASE_SRC_TX -- requirements
Module: cdc_2phase_src_tx

Interface
REQ-001 SHALL have parameter T, default logic, payload type transported across the crossing.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, ack synchronizer depth; values below 2 SHALL be rejected at elaboration.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 0, ack-wait watchdog limit; 0 disables the watchdog.
REQ-004 clk_i  input  1  sole clock; all state SHALL be updated on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 clr_i  input  1  synchronous soft clear.
REQ-007 src_data_i  input  $bits(T)  payload to send.
REQ-008 src_valid_i  input  1  payload valid.
REQ-009 src_ready_o  output  1  payload accepted when valid and ready are both high at a rising edge.
REQ-010 async_req_o  output  1  2-phase request; each toggle is one transfer.
REQ-011 async_data_o  output  $bits(T)  payload held stable for the receiving domain.
REQ-012 async_ack_i  input  1  2-phase acknowledge toggle from the receiving domain; asynchronous to clk_i.
REQ-013 busy_o  output  1  transfer in flight.
REQ-014 timeout_o  output  1  sticky watchdog flag.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and WAIT_ACK.
REQ-016 async_ack_i SHALL pass through a SYNC_STAGES-deep flop chain; ack_sync is the last stage; no other logic SHALL sample async_ack_i.
REQ-017 src_ready_o SHALL be high iff state is IDLE and clr_i is low; it SHALL have no combinational dependency on src_valid_i or async_ack_i.
REQ-018 On accept in IDLE: data_q <= src_data_i, req_q <= ~req_q, state <= WAIT_ACK, all at the same edge.
REQ-019 async_req_o SHALL equal req_q and async_data_o SHALL equal data_q; both are driven directly from flops, with no glitching logic.
REQ-020 data_q SHALL change only on accept; it SHALL be held through WAIT_ACK and the following IDLE.
REQ-021 In WAIT_ACK: when ack_sync == req_q, state <= IDLE at that edge; otherwise state SHALL remain WAIT_ACK.
REQ-022 Timing: with SYNC_STAGES=2 and async_ack_i toggled before edge e, the FSM SHALL enter IDLE at edge e+2, and src_ready_o SHALL be high after e+2.
REQ-023 Back-to-back: at most one transfer SHALL be in flight; req_q SHALL NOT toggle in WAIT_ACK.
REQ-024 In IDLE, an ack_sync change (ack_sync != req_q) SHALL be ignored: no state, req_q or data_q change.
REQ-025 busy_o SHALL be high iff state is WAIT_ACK.
REQ-026 Watchdog (TIMEOUT_CYCLES>0): cnt_q counts cycles spent in WAIT_ACK; it saturates at TIMEOUT_CYCLES and resets to 0 on entry to WAIT_ACK.
REQ-027 timeout_o SHALL be set at the edge where cnt_q reaches TIMEOUT_CYCLES, and SHALL stay set across later transfers until rst_i or clr_i.
REQ-028 With TIMEOUT_CYCLES=0, timeout_o SHALL be constant 0 and no counter SHALL be inferred.
REQ-029 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1).
REQ-030 clr_i high SHALL clear timeout_o and cnt_q and hold src_ready_o low.
REQ-031 clr_i SHALL NOT abort an in-flight transfer: in WAIT_ACK the FSM still completes on ack, and req_q and data_q are preserved so the phase stays aligned.
REQ-032 clr_i and src_valid_i high together: no accept.
REQ-033 rst_i SHALL have priority over clr_i and all other events.

Reset
REQ-034 While rst_i is high at an edge: state=IDLE, req_q=0, data_q='0, synchronizer flops=0, cnt_q=0, timeout_o=0.
REQ-035 After reset: src_ready_o=1, async_req_o=0, async_data_o='0, busy_o=0, timeout_o=0.
REQ-036 Reset mid-transfer SHALL return the block to IDLE; the receiver SHALL be reset simultaneously so that async_ack_i is 0 when rst_i deasserts.

Verification
REQ-037 rst_i high 2 cycles, then low -> src_ready_o=1, async_req_o=0, async_data_o=0x00, busy_o=0, timeout_o=0.
REQ-038 T=logic[7:0]: send 0xA5, toggle ack 1 cycle after req -> async_req_o 0->1, async_data_o=0xA5 stable, busy_o high, src_ready_o high exactly 2 edges after ack toggle.
REQ-039 src_valid_i held with 0x01 then 0x02, ack echoed -> exactly two req toggles (0->1->0), second toggle only after first ack synced, data 0x01 held until second accept.
REQ-040 TIMEOUT_CYCLES=4, no ack -> timeout_o rises after 4 cycles in WAIT_ACK; late ack returns FSM to IDLE while timeout_o stays 1; clr_i pulse -> timeout_o=0.
REQ-041 clr_i high during WAIT_ACK -> busy_o stays 1, src_ready_o 0, no req toggle; ack arrives, clr_i drops -> src_ready_o=1, next transfer toggles req normally.
REQ-042 In IDLE, toggle async_ack_i spuriously -> state, async_req_o, async_data_o unchanged; src_ready_o stays 1.
